// File: rtl/sdio_xfer_ctrl.sv
// SD/SDIO block-transfer sequencer: issues the read/write command, steps the
// data engines block by block, waits out card programming, closes multi-block
// and aborted transfers with CMD12, and reports completion with an error flag.
module sdio_xfer_ctrl #(
    parameter int LGBLKSZ   = 9,
    parameter int OPT_HCS   = 1,
    parameter int LGTIMEOUT = 20
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_sector,
    input  logic [15:0] i_count,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [5:0]  o_cmd,
    output logic [31:0] o_cmd_arg,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_err,
    input  logic [31:0] i_rsp_r1,
    output logic        o_rx_en,
    input  logic        i_rx_done,
    input  logic        i_rx_err,
    output logic        o_tx_en,
    input  logic        i_tx_done,
    input  logic        i_tx_err,
    input  logic        i_card_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_RSP     = 3'd2,
        S_DATA    = 3'd3,
        S_PROG    = 3'd4,
        S_STOP    = 3'd5,
        S_STOPRSP = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [LGTIMEOUT-1:0] WD_ONE = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    localparam logic [LGTIMEOUT-1:0] WD_MAX = {LGTIMEOUT{1'b1}};

    // Read/write, single/multi command selection.
    function automatic logic [5:0] cmd_index(input logic wr, input logic [15:0] cnt);
        logic multi;
        multi = (cnt > 16'd1);
        case ({wr, multi})
            2'b00:   return 6'd17;
            2'b01:   return 6'd18;
            2'b10:   return 6'd24;
            2'b11:   return 6'd25;
            default: return 6'd17;
        endcase
    endfunction

    // High-capacity cards take a block number, standard cards a byte address.
    function automatic logic [31:0] sector_arg(input logic [31:0] sector);
        logic [31:0] shifted;
        shifted = sector << LGBLKSZ;
        if (OPT_HCS != 0) begin
            return sector;
        end else begin
            return shifted;
        end
    endfunction

    state_t               state_r, state_s;
    logic                 write_r, write_s;
    logic                 multi_r, multi_s;
    logic [15:0]          count_r, count_s;
    logic                 err_r, err_s;
    logic                 rsp_seen_r, rsp_seen_s;
    logic [5:0]           cmd_r, cmd_s;
    logic [31:0]          arg_r, arg_s;
    logic [LGTIMEOUT-1:0] wd_r;
    logic                 blk_done_s;
    logic                 busy_r, done_r, err_out_r, cmd_valid_r, rx_en_r, tx_en_r;

    // Only the R1 error bits steer the sequence; the status bits are don't-care.
    logic unused_s;
    assign unused_s = ^i_rsp_r1[18:0];

    logic   wd_exp_s, rsp_ok_s, fault_s;
    state_t fin_s;
    assign wd_exp_s = (wd_r == WD_MAX);
    assign rsp_ok_s = !i_rsp_err && (i_rsp_r1[31:19] == 13'd0);
    assign fault_s  = i_rx_err || i_tx_err || wd_exp_s;
    assign fin_s    = multi_r ? S_STOP : S_DONE;

    // Next-state and datapath decisions for the transfer sequence.
    always_comb begin
        state_s    = state_r;
        write_s    = write_r;
        multi_s    = multi_r;
        count_s    = count_r;
        err_s      = err_r;
        rsp_seen_s = rsp_seen_r;
        cmd_s      = cmd_r;
        arg_s      = arg_r;
        blk_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_req) begin
                    write_s    = i_write;
                    multi_s    = (i_count > 16'd1);
                    count_s    = i_count;
                    err_s      = 1'b0;
                    rsp_seen_s = 1'b0;
                    cmd_s      = cmd_index(i_write, i_count);
                    arg_s      = sector_arg(i_sector);
                    state_s    = (i_count == 16'd0) ? S_DONE : S_CMD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CMD: begin
                state_s = i_cmd_ready ? S_RSP : S_CMD;
            end
            S_RSP: begin
                if (fault_s) begin
                    err_s   = 1'b1;
                    state_s = fin_s;
                end else if (i_rsp_valid) begin
                    if (rsp_ok_s) begin
                        state_s = S_DATA;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_RSP;
                end
            end
            S_DATA: begin
                if (fault_s) begin
                    err_s   = 1'b1;
                    state_s = fin_s;
                end else if (i_abort) begin
                    state_s = S_STOP;
                end else if (write_r) begin
                    state_s = i_tx_done ? S_PROG : S_DATA;
                end else if (i_rx_done) begin
                    blk_done_s = 1'b1;
                    if (count_r <= 16'd1) begin
                        count_s = 16'd0;
                        state_s = fin_s;
                    end else begin
                        count_s = count_r - 16'd1;
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PROG: begin
                if (fault_s) begin
                    err_s   = 1'b1;
                    state_s = fin_s;
                end else if (i_abort) begin
                    state_s = S_STOP;
                end else if (!i_card_busy) begin
                    blk_done_s = 1'b1;
                    if (count_r <= 16'd1) begin
                        count_s = 16'd0;
                        state_s = fin_s;
                    end else begin
                        count_s = count_r - 16'd1;
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_PROG;
                end
            end
            S_STOP: begin
                state_s = i_cmd_ready ? S_STOPRSP : S_STOP;
            end
            S_STOPRSP: begin
                if (wd_exp_s) begin
                    err_s   = 1'b1;
                    state_s = S_DONE;
                end else if (!rsp_seen_r) begin
                    if (i_rsp_valid) begin
                        rsp_seen_s = 1'b1;
                        err_s      = err_r || !rsp_ok_s;
                    end else begin
                        rsp_seen_s = 1'b0;
                    end
                end else if (!i_card_busy) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_STOPRSP;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, transfer context and registered outputs (decoded from next state).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= S_IDLE;
            write_r     <= 1'b0;
            multi_r     <= 1'b0;
            count_r     <= 16'd0;
            err_r       <= 1'b0;
            rsp_seen_r  <= 1'b0;
            cmd_r       <= 6'd0;
            arg_r       <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_out_r   <= 1'b0;
            cmd_valid_r <= 1'b0;
            rx_en_r     <= 1'b0;
            tx_en_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            write_r     <= write_s;
            multi_r     <= multi_s;
            count_r     <= count_s;
            err_r       <= err_s;
            rsp_seen_r  <= (state_s == S_STOP) ? 1'b0 : rsp_seen_s;
            cmd_r       <= (state_s == S_STOP) ? 6'd12 : cmd_s;
            arg_r       <= (state_s == S_STOP) ? 32'd0 : arg_s;
            busy_r      <= (state_s != S_IDLE);
            done_r      <= (state_s == S_DONE);
            err_out_r   <= (state_s == S_DONE) && err_s;
            cmd_valid_r <= (state_s == S_CMD) || (state_s == S_STOP);
            rx_en_r     <= (state_s == S_DATA) && !write_s;
            tx_en_r     <= (state_s == S_DATA) && write_s;
        end
    end

    // Per-state watchdog, restarted on every state change and block completion.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_r <= '0;
        end else if ((state_s != state_r) || blk_done_s || (state_r == S_IDLE)) begin
            wd_r <= '0;
        end else if (!wd_exp_s) begin
            wd_r <= wd_r + WD_ONE;
        end else begin
            wd_r <= wd_r;
        end
    end

    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_err       = err_out_r;
    assign o_cmd_valid = cmd_valid_r;
    assign o_cmd       = cmd_r;
    assign o_cmd_arg   = arg_r;
    assign o_rx_en     = rx_en_r;
    assign o_tx_en     = tx_en_r;

endmodule

// File: tb/tb_sdio_xfer_ctrl.sv
// Self-checking bench: acts as the card/command/data engines with randomized
// timing and compares each transfer against a transaction-level model.
module tb_sdio_xfer_ctrl;

    localparam int LGT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, write = 1'b0, abort = 1'b0;
    logic [31:0] sector = 32'd0;
    logic [15:0] count = 16'd0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_r1 = 32'd0;
    logic        rx_done = 1'b0, rx_err = 1'b0, tx_done = 1'b0, tx_err = 1'b0;
    logic        card_busy = 1'b0;

    logic        h_busy, h_done, h_err, h_cmd_valid, h_rx_en, h_tx_en;
    logic [5:0]  h_cmd;
    logic [31:0] h_arg;
    logic        b_busy, b_done, b_err, b_cmd_valid, b_rx_en, b_tx_en;
    logic [5:0]  b_cmd;
    logic [31:0] b_arg;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sdio_xfer_ctrl #(.LGBLKSZ(9), .OPT_HCS(1), .LGTIMEOUT(LGT)) u_hcs (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_write(write),
        .i_sector(sector), .i_count(count), .i_abort(abort),
        .o_busy(h_busy), .o_done(h_done), .o_err(h_err),
        .o_cmd_valid(h_cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd(h_cmd), .o_cmd_arg(h_arg),
        .i_rsp_valid(rsp_valid), .i_rsp_err(rsp_err), .i_rsp_r1(rsp_r1),
        .o_rx_en(h_rx_en), .i_rx_done(rx_done), .i_rx_err(rx_err),
        .o_tx_en(h_tx_en), .i_tx_done(tx_done), .i_tx_err(tx_err), .i_card_busy(card_busy)
    );

    sdio_xfer_ctrl #(.LGBLKSZ(9), .OPT_HCS(0), .LGTIMEOUT(LGT)) u_byte (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_write(write),
        .i_sector(sector), .i_count(count), .i_abort(abort),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
        .o_cmd_valid(b_cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd(b_cmd), .o_cmd_arg(b_arg),
        .i_rsp_valid(rsp_valid), .i_rsp_err(rsp_err), .i_rsp_r1(rsp_r1),
        .o_rx_en(b_rx_en), .i_rx_done(rx_done), .i_rx_err(rx_err),
        .o_tx_en(b_tx_en), .i_tx_done(tx_done), .i_tx_err(tx_err), .i_card_busy(card_busy)
    );

    task automatic clear_pulses();
        req = 1'b0; abort = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        rsp_r1 = 32'd0; rx_done = 1'b0; rx_err = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
    endtask

    // kind: 0 clean, 1 data error at block k, 2 abort at block k,
    //       3 R1 bit 22 on first response, 4 CRC/no-response on first response
    task automatic run_xfer(input string tag, input bit wr, input int cnt, input logic [31:0] sec,
                            input int kind, input int k, input bit stop_bad);
        bit          exp_err, exp_stop, exp_data, got_err, done_seen, drop_chk;
        int          exp_blocks, n_good, blk, rsp_wait, busy_cnt, en_seen, exp_ncmd;
        logic [5:0]  c0;
        logic [31:0] exp_ab;
        logic [5:0]  q_cmd[$];
        logic [31:0] q_ah[$];
        logic [31:0] q_ab[$];
        // transaction-level expectation
        c0     = wr ? ((cnt == 1) ? 6'd24 : 6'd25) : ((cnt == 1) ? 6'd17 : 6'd18);
        exp_ab = sec * 32'd512;
        if (cnt == 0) begin
            exp_err = 1'b0; exp_blocks = 0; exp_stop = 1'b0; exp_data = 1'b0;
        end else if (kind == 1) begin
            exp_err = 1'b1; exp_blocks = k - 1; exp_stop = (cnt > 1); exp_data = 1'b1;
        end else if (kind == 2) begin
            exp_err = 1'b0; exp_blocks = k - 1; exp_stop = 1'b1; exp_data = 1'b1;
        end else if (kind >= 3) begin
            exp_err = 1'b1; exp_blocks = 0; exp_stop = 1'b0; exp_data = 1'b0;
        end else begin
            exp_err = 1'b0; exp_blocks = cnt; exp_stop = (cnt > 1); exp_data = 1'b1;
        end
        if (exp_stop && stop_bad) exp_err = 1'b1;
        exp_ncmd = (cnt == 0) ? 0 : (exp_stop ? 2 : 1);

        @(negedge clk);
        req = 1'b1; write = wr; count = cnt[15:0]; sector = sec;
        got_err = 1'b0; done_seen = 1'b0; drop_chk = 1'b0;
        n_good = 0; blk = 0; rsp_wait = 0; busy_cnt = 0; en_seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (h_busy !== 1'b1) $display("FAIL %s busy: got %0b want 1", tag, h_busy); else n_pass++;
            if (drop_chk) begin
                n_chk++;
                if ({h_rx_en, h_tx_en} !== 2'b00)
                    $display("FAIL %s en_drop: got rx=%0b tx=%0b want 0", tag, h_rx_en, h_tx_en);
                else n_pass++;
            end
            if (card_busy) begin
                n_chk++;
                if ({h_tx_en, h_done} !== 2'b00)
                    $display("FAIL %s card_busy_hold: got tx=%0b done=%0b want 0", tag, h_tx_en, h_done);
                else n_pass++;
            end
            drop_chk = 1'b0;
            if (h_rx_en || h_tx_en) en_seen++;
            clear_pulses();
            write = $urandom_range(0, 1); count = 16'($urandom); sector = $urandom;
            if (h_done) begin
                done_seen = 1'b1; got_err = h_err; busy_cnt = 0; card_busy = 1'b0;
                break;
            end
            if (busy_cnt > 0) busy_cnt--;
            card_busy = (busy_cnt > 0);
            if (h_cmd_valid && ($urandom_range(0, 1) == 1)) begin
                cmd_ready = 1'b1;
                q_cmd.push_back(h_cmd); q_ah.push_back(h_arg); q_ab.push_back(b_arg);
                rsp_wait = $urandom_range(1, 3);
            end else if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_r1 = $urandom & 32'h0007_FFFF;
                    if (q_cmd.size() == 1 && kind == 3) rsp_r1[22] = 1'b1;
                    if (q_cmd.size() == 1 && kind == 4) rsp_err = 1'b1;
                    if (q_cmd.size() > 1) begin
                        rsp_err = stop_bad;
                        busy_cnt = $urandom_range(0, 3);
                        card_busy = (busy_cnt > 0);
                    end
                end
            end
            if ((h_rx_en || h_tx_en) && ($urandom_range(0, 9) < 4)) begin
                blk++;
                drop_chk = 1'b1;
                if (kind == 1 && blk == k) begin
                    if (h_rx_en) begin rx_err = 1'b1; rx_done = $urandom_range(0, 1); end
                    else tx_err = 1'b1;
                end else if (kind == 2 && blk == k) begin
                    abort = 1'b1;
                end else if (h_rx_en) begin
                    rx_done = 1'b1; n_good++;
                    drop_chk = (blk == cnt);
                end else begin
                    tx_done = 1'b1; n_good++;
                    busy_cnt = $urandom_range(1, 4);
                    card_busy = 1'b1;
                end
            end
            // a request while busy carries garbage and must be ignored
            if ($urandom_range(0, 9) == 0) req = 1'b1;
        end
        n_chk++;
        if (!done_seen) $display("FAIL %s done_timeout: got no o_done want o_done", tag); else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({h_done, h_busy} !== 2'b00) $display("FAIL %s idle_after_done: got done=%0b busy=%0b want 0", tag, h_done, h_busy);
        else n_pass++;
        n_chk++;
        if (got_err !== exp_err) $display("FAIL %s err: got %0b want %0b", tag, got_err, exp_err); else n_pass++;
        n_chk++;
        if (n_good !== exp_blocks) $display("FAIL %s blocks: got %0d want %0d", tag, n_good, exp_blocks); else n_pass++;
        n_chk++;
        if ((en_seen > 0) !== exp_data) $display("FAIL %s data_phase: got %0b want %0b", tag, en_seen > 0, exp_data);
        else n_pass++;
        n_chk++;
        if (q_cmd.size() !== exp_ncmd) $display("FAIL %s ncmd: got %0d want %0d", tag, q_cmd.size(), exp_ncmd);
        else n_pass++;
        if (q_cmd.size() >= 1 && exp_ncmd >= 1) begin
            n_chk++;
            if ({q_cmd[0], q_ah[0], q_ab[0]} !== {c0, sec, exp_ab})
                $display("FAIL %s cmd0: got %0d/%h/%h want %0d/%h/%h", tag, q_cmd[0], q_ah[0], q_ab[0], c0, sec, exp_ab);
            else n_pass++;
        end
        if (q_cmd.size() >= 2 && exp_ncmd >= 2) begin
            n_chk++;
            if ({q_cmd[1], q_ah[1], q_ab[1]} !== {6'd12, 32'd0, 32'd0})
                $display("FAIL %s cmd12: got %0d/%h/%h want 12/0/0", tag, q_cmd[1], q_ah[1], q_ab[1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [95:0] outs;
        repeat (3) @(negedge clk);
        outs = {h_busy, h_done, h_err, h_cmd_valid, h_cmd, h_arg, h_rx_en, h_tx_en,
                b_busy, b_done, b_err, b_cmd_valid, b_cmd, b_arg, b_rx_en, b_tx_en};
        n_chk++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int waited;
        bit seen;
        logic [5:0] c;
        c = 6'd0; waited = 0; seen = 1'b0;
        @(negedge clk);
        req = 1'b1; write = 1'b0; count = 16'd1; sector = 32'd9;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 20 && !h_cmd_valid; i++) @(negedge clk);
        c = h_cmd;
        cmd_ready = 1'b1;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            cmd_ready = 1'b0;
            if (h_done) begin waited = i; seen = 1'b1; break; end
        end
        n_chk++;
        if (!seen || h_err !== 1'b1) $display("FAIL watchdog_err: got done=%0b err=%0b want 1/1", seen, h_err);
        else n_pass++;
        n_chk++;
        if (waited < (1 << LGT) - 2 || waited > (1 << LGT) + 4)
            $display("FAIL watchdog_time: got %0d cycles want about %0d", waited, (1 << LGT) + 1);
        else n_pass++;
        n_chk++;
        if (c !== 6'd17) $display("FAIL watchdog_cmd: got %0d want 17", c); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [95:0] outs;
        @(negedge clk);
        req = 1'b1; write = 1'b1; count = 16'd3; sector = 32'd77;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 20 && !h_cmd_valid; i++) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_r1 = 32'd0;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 20 && !h_tx_en; i++) @(negedge clk);
        tx_done = 1'b1; card_busy = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({h_busy, h_tx_en, h_rx_en} !== 3'b100) $display("FAIL prog_wait: got %b want 100", {h_busy, h_tx_en, h_rx_en});
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        outs = {h_busy, h_done, h_err, h_cmd_valid, h_cmd, h_arg, h_rx_en, h_tx_en,
                b_busy, b_done, b_err, b_cmd_valid, b_cmd, b_arg, b_rx_en, b_tx_en};
        n_chk++;
        if (outs !== '0) $display("FAIL reset_mid_outputs: got %h want 0", outs); else n_pass++;
        @(negedge clk);
        card_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if ({h_done, h_busy} !== 2'b00) $display("FAIL reset_mid_quiet: got done=%0b busy=%0b want 0", h_done, h_busy);
            else n_pass++;
        end
        run_xfer("after_reset", 1'b1, 3, 32'd2, 0, 1, 1'b0);
    endtask

    task automatic test_single_read();
        run_xfer("single_read", 1'b0, 1, 32'd5, 0, 1, 1'b0);
    endtask

    task automatic test_multi_write();
        run_xfer("multi_write", 1'b1, 3, 32'd2, 0, 1, 1'b0);
    endtask

    task automatic test_read_error();
        run_xfer("read_err_blk2", 1'b0, 4, 32'h1234, 1, 2, 1'b0);
        run_xfer("single_wr_err", 1'b1, 1, 32'h55, 1, 1, 1'b0);
    endtask

    task automatic test_bad_response();
        run_xfer("bad_r1", 1'b0, 3, 32'd40, 3, 1, 1'b0);
        run_xfer("no_rsp", 1'b1, 1, 32'd41, 4, 1, 1'b0);
        run_xfer("bad_stop_rsp", 1'b0, 2, 32'd42, 0, 1, 1'b1);
    endtask

    task automatic test_zero_count_and_abort();
        run_xfer("zero_count", 1'b0, 0, 32'd8, 0, 1, 1'b0);
        run_xfer("abort_single", 1'b1, 1, 32'd9, 2, 1, 1'b0);
        run_xfer("abort_multi", 1'b0, 4, 32'd10, 2, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int cnt;
            cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            run_xfer("random", 1'($urandom_range(0, 1)), cnt, $urandom, $urandom_range(0, 4),
                     $urandom_range(1, (cnt > 0) ? cnt : 1), ($urandom_range(0, 5) == 0));
        end
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b_a", 1'b1, 2, 32'hFFFF_FFFF, 0, 1, 1'b0);
        run_xfer("b2b_b", 1'b0, 2, 32'h0080_0001, 0, 1, 1'b0);
        run_xfer("b2b_c", 1'b0, 1, 32'd0, 0, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_write();
        test_read_error();
        test_bad_response();
        test_zero_count_and_abort();
        test_watchdog();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdio_xfer_ctrl.md
SDIO_XFER_CTRL -- requirements
Module: sdio_xfer_ctrl

Interface
REQ-001 SHALL have parameter LGBLKSZ, default 9, giving the log2 block size in bytes.
REQ-002 SHALL have parameter OPT_HCS, default 1: 1 = block-addressed argument, 0 = byte-addressed argument.
REQ-003 SHALL have parameter LGTIMEOUT, default 20: watchdog limit of 2^LGTIMEOUT clocks per wait state.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports, clock and reset first:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  start transfer
- i_write  in  1  1 = write, 0 = read
- i_sector  in  32  start block number
- i_count  in  16  block count
- i_abort  in  1  request early stop
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  error flag, valid with o_done
- o_cmd_valid  out  1  command request
- i_cmd_ready  in  1  command engine accepts command
- o_cmd  out  6  command index
- o_cmd_arg  out  32  command argument
- i_rsp_valid  in  1  R1 response strobe
- i_rsp_err  in  1  response CRC error or no response
- i_rsp_r1  in  32  R1 status
- o_rx_en  out  1  enable receive-data engine
- i_rx_done  in  1  block received, CRC good
- i_rx_err  in  1  receive CRC or framing error
- o_tx_en  out  1  enable transmit-data engine
- i_tx_done  in  1  block sent, CRC status positive
- i_tx_err  in  1  CRC status negative
- i_card_busy  in  1  DAT0 held low by card

Function
REQ-005 States SHALL be IDLE, CMD, RSP, DATA, PROG, STOP, STOPRSP, DONE.
REQ-006 IDLE, i_req=1: latch i_write, i_count and the argument; go to CMD. i_req outside IDLE SHALL be ignored.
REQ-007 i_count=0 SHALL go directly to DONE with o_err=0; no command is issued.
REQ-008 o_cmd SHALL be: read, count=1 -> 17; read, count>1 -> 18; write, count=1 -> 24; write, count>1 -> 25.
REQ-009 o_cmd_arg SHALL equal i_sector when OPT_HCS=1, else i_sector<<LGBLKSZ truncated to 32 bits.
REQ-010 In CMD and STOP, o_cmd_valid SHALL stay 1, with o_cmd and o_cmd_arg stable, until the cycle i_cmd_ready=1; the next state is RSP or STOPRSP respectively.
REQ-011 In RSP, i_rsp_valid with i_rsp_err=0 and i_rsp_r1[31:19]=0 SHALL go to DATA; any other response SHALL go to DONE with error.
REQ-012 DATA, read: o_rx_en=1. Each i_rx_done SHALL decrement the remaining count. At zero: multi-block goes to STOP, single goes to DONE.
REQ-013 DATA, write: o_tx_en=1. i_tx_done SHALL go to PROG.
REQ-014 PROG SHALL wait for i_card_busy=0, then decrement the count. Nonzero -> DATA. Zero -> STOP (multi) or DONE (single).
REQ-015 In DATA, PROG and RSP, i_rx_err, i_tx_err or watchdog expiry SHALL set a sticky error flag. Multi-block then goes to STOP; single goes to DONE.
REQ-016 i_abort in DATA or PROG SHALL go to STOP, even for single-block, without setting the error flag.
REQ-017 STOP SHALL issue CMD12 with argument 0.
REQ-018 STOPRSP SHALL wait for i_rsp_valid, then for i_card_busy=0. A bad response or watchdog expiry SHALL set the error flag. Next state is DONE.
REQ-019 The watchdog SHALL clear on every state change and on every block completion, and SHALL expire when it reaches 2^LGTIMEOUT-1.
REQ-020 o_rx_en and o_tx_en SHALL drop in the same cycle DATA is exited.
REQ-021 DONE SHALL last exactly one cycle, with o_done=1 and o_err = the sticky error flag; the next state is IDLE.
REQ-022 o_busy SHALL be 1 in every state except IDLE.
REQ-023 The remaining count SHALL be 16 bits and SHALL never wrap below zero.
REQ-024 i_rx_done and i_rx_err arriving in the same cycle: error SHALL take precedence.

Reset
REQ-025 Reset asserted SHALL force state IDLE and set every output to 0, the error flag to 0 and the watchdog to 0, regardless of the current state.
REQ-026 Reset asserted mid-transfer SHALL discard the transfer; no o_done pulse SHALL be generated.

Verification
REQ-027 Read, count=1, sector=5, OPT_HCS=1 -> CMD17 with arg 5; one i_rx_done -> o_done=1, o_err=0; no CMD12 issued.
REQ-028 Write, count=3, sector=2, OPT_HCS=0 -> CMD25 with arg 0x400; three tx/PROG cycles, each held while i_card_busy=1; then CMD12; o_done=1, o_err=0.
REQ-029 Read, count=4, i_rx_err on block 2 -> CMD12 issued; o_done=1, o_err=1; o_rx_en low from the cycle after the error.
REQ-030 Response with i_rsp_r1[22]=1 on CMD18 -> o_done=1, o_err=1; o_rx_en never asserted; no CMD12.
REQ-031 No response in RSP for 2^LGTIMEOUT clocks -> o_done=1, o_err=1.
REQ-032 Reset asserted during PROG -> all outputs 0 immediately; a following i_req=1 starts a clean transfer.
